vga_syncgen: RTL and testbench

//   VGA 640x480@60Hz timing generator. Runs on a 25 MHz pixel clock (40 ns period).

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_syncgen_if.sv | 14 +
 rtl/vga_syncgen_counter.sv | 40 ++++
 rtl/vga_syncgen.sv | 71 +++++++
 tb/tb_vga_syncgen.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants for 640x480@60Hz VGA on a 25 MHz pixel clock.
// Sync positions are half-open windows [start, end) in counter units.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Active level of both sync pulses; 0 means active-low.
    localparam bit SYNC_POL = 1'b0;

    localparam int CNT_W   = 10;
    localparam int PIXEL_W = 10;
    localparam int LINE_W  = 9;

endpackage

// File: rtl/vga_syncgen_if.sv
// Video timing bundle from the sync generator to the pixel renderer.
// No handshake: every signal is valid on every clock and describes the current position.
interface vga_syncgen_if;
    import vga_timing_pkg::*;

    logic               h_sync;
    logic               v_sync;
    logic [PIXEL_W-1:0] pixel;
    logic [LINE_W-1:0]  line;

    modport master (output h_sync, output v_sync, output pixel, output line);
    modport slave  (input  h_sync, input  v_sync, input  pixel, input  line);

endinterface

// File: rtl/vga_syncgen_counter.sv
// Modulo-N counter with enable, wrap strobe and a pulse-window decode of the
// value being loaded, so the consumer can register outputs with zero latency.
module sync_counter #(
    parameter int W       = 10,
    parameter int N       = 800,
    parameter int P_START = 656,
    parameter int P_END   = 752
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt_next,
    output logic         wrap,
    output logic         pulse_next
);

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] PS   = W'(P_START);
    localparam logic [W-1:0] PE   = W'(P_END);

    logic [W-1:0] cnt;

    always_comb begin
        wrap     = en && (cnt == LAST);
        cnt_next = cnt;
        if (en) begin
            cnt_next = (cnt == LAST) ? '0 : cnt + W'(1);
        end
        pulse_next = (cnt_next >= PS) && (cnt_next < PE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/vga_syncgen.sv
// VGA sync generator top: horizontal/vertical counters plus registered
// sync, pixel and line outputs decoded from the next counter values.
module vga_syncgen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS    = H_VISIBLE,
    parameter int H_FP     = H_FRONT,
    parameter int H_SW     = H_SYNC,
    parameter int H_BP     = H_BACK,
    parameter int V_VIS    = V_VISIBLE,
    parameter int V_FP     = V_FRONT,
    parameter int V_SW     = V_SYNC,
    parameter int V_BP     = V_BACK,
    parameter bit SYNC_ACT = SYNC_POL
) (
    input  logic           clk,
    input  logic           reset,
    vga_syncgen_if.master  vga
);

    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int H_SS  = H_VIS + H_FP;
    localparam int H_SE  = H_SS + H_SW;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int V_SS  = V_VIS + V_FP;
    localparam int V_SE  = V_SS + V_SW;

    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_wrap;
    logic             h_pulse;
    logic             v_pulse;
    logic             unused_v_wrap;

    sync_counter #(.W(CNT_W), .N(H_TOT), .P_START(H_SS), .P_END(H_SE)) u_h_cnt (
        .clk        (clk),
        .reset      (reset),
        .en         (1'b1),
        .cnt_next   (h_next),
        .wrap       (h_wrap),
        .pulse_next (h_pulse)
    );

    // The vertical counter steps once per line, on the horizontal wrap.
    sync_counter #(.W(CNT_W), .N(V_TOT), .P_START(V_SS), .P_END(V_SE)) u_v_cnt (
        .clk        (clk),
        .reset      (reset),
        .en         (h_wrap),
        .cnt_next   (v_next),
        .wrap       (unused_v_wrap),
        .pulse_next (v_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vga.h_sync <= ~SYNC_ACT;
            vga.v_sync <= ~SYNC_ACT;
            vga.pixel  <= '0;
            vga.line   <= '0;
        end else begin
            vga.h_sync <= h_pulse ? SYNC_ACT : ~SYNC_ACT;
            vga.v_sync <= v_pulse ? SYNC_ACT : ~SYNC_ACT;
            vga.pixel  <= (h_next < H_VIS_C && v_next < V_VIS_C) ? PIXEL_W'(h_next) : '0;
            vga.line   <= (v_next < V_VIS_C) ? LINE_W'(v_next) : '0;
        end
    end

endmodule

// File: tb/tb_vga_syncgen.sv
// Bench for vga_syncgen: a full-size instance and a vertically shortened one
// are checked against a position-arithmetic model on sampled clocks.
module tb_vga_syncgen;

    localparam int HT  = 800;
    localparam int HV  = 640;
    localparam int HSS = 656;
    localparam int HSE = 752;

    localparam int FULL_VT  = 525;
    localparam int FULL_VV  = 480;
    localparam int FULL_VSS = 490;
    localparam int FULL_VSE = 492;

    // Short frame: 20 visible + 3 front + 2 sync + 4 back = 29 lines.
    localparam int SM_VT  = 29;
    localparam int SM_VV  = 20;
    localparam int SM_VSS = 23;
    localparam int SM_VSE = 25;
    localparam int SM_FRAME = SM_VT * HT;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #20 clk = ~clk;

    vga_syncgen_if full_if ();
    vga_syncgen_if small_if ();

    vga_syncgen dut_full (
        .clk   (clk),
        .reset (reset),
        .vga   (full_if)
    );

    vga_syncgen #(.V_VIS(SM_VV), .V_FP(3), .V_SW(2), .V_BP(4)) dut_small (
        .clk   (clk),
        .reset (reset),
        .vga   (small_if)
    );

    int t = 0;
    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];
    int h_marks[10] = '{0, 1, 2, 639, 640, 655, 656, 751, 752, 799};

    // Expected {h_sync, v_sync, pixel, line} for tt clocks after reset release.
    function automatic logic [20:0] model(int tt, int vt, int vv, int vss, int vse);
        int x;
        int y;
        logic hs;
        logic vs;
        logic [9:0] px;
        logic [8:0] ln;
        x  = tt % HT;
        y  = (tt / HT) % vt;
        hs = !(x >= HSS && x < HSE);
        vs = !(y >= vss && y < vse);
        px = (x < HV && y < vv) ? 10'(x) : 10'd0;
        ln = (y < vv) ? 9'(y) : 9'd0;
        return {hs, vs, px, ln};
    endfunction

    task automatic check(string tag, int obs, int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    task automatic score_one(string who, logic hs, logic vs, logic [9:0] px, logic [8:0] ln);
        logic [20:0] e;
        e = exp_q.pop_front();
        check({who, "_hsync"}, int'(hs), int'(e[20]));
        check({who, "_vsync"}, int'(vs), int'(e[19]));
        check({who, "_pixel"}, int'(px), int'(e[18:9]));
        check({who, "_line"},  int'(ln), int'(e[8:0]));
    endtask

    task automatic sample(int tt);
        exp_q.push_back(model(tt, FULL_VT, FULL_VV, FULL_VSS, FULL_VSE));
        exp_q.push_back(model(tt, SM_VT, SM_VV, SM_VSS, SM_VSE));
        score_one("full",  full_if.h_sync,  full_if.v_sync,  full_if.pixel,  full_if.line);
        score_one("small", small_if.h_sync, small_if.v_sync, small_if.pixel, small_if.line);
    endtask

    function automatic bit want(int tt);
        int x;
        x = tt % HT;
        foreach (h_marks[i]) begin
            if (x == h_marks[i]) return 1'b1;
        end
        return ($urandom_range(0, 31) == 0);
    endfunction

    task automatic run_to(int t_end);
        while (t < t_end) begin
            @(negedge clk);
            t++;
            if (want(t)) sample(t);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        t = 0;
        sample(0);
        reset = 1'b0;
    endtask

    initial begin
        int k;
        int hs_low;
        int vs_low;

        // Three reset clocks, then release and run past one short frame.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        t = 0;
        sample(0);
        reset = 1'b0;
        run_to(SM_FRAME + HT);

        // One-clock reset inside an h_sync pulse, then a full restart.
        k = $urandom_range(0, 9);
        run_to(SM_FRAME + HT + k * HT + 700);
        pulse_reset();
        run_to(SM_FRAME + HT);

        // Long reset hold: outputs must stay at reset values, no pulses.
        hs_low = 0;
        vs_low = 0;
        reset = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            hs_low += int'(!full_if.h_sync) + int'(!small_if.h_sync);
            vs_low += int'(!full_if.v_sync) + int'(!small_if.v_sync);
            if (i % 500 == 0 || $urandom_range(0, 31) == 0) begin
                t = 0;
                sample(0);
            end
        end
        check("hold_hsync_low_cycles", hs_low, 0);
        check("hold_vsync_low_cycles", vs_low, 0);
        t = 0;
        reset = 1'b0;
        run_to(HT + 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
